// File: rtl/sprite_line_engine.sv
// Per-scanline sprite engine: scans a double-buffered attribute RAM for sprites
// on the next line, keeps up to MAX_SLOT hits, then streams their pattern rows into the line buffer.
module sprite_line_engine #(
    parameter int              NUM_SPRITE = 32,
    parameter int              MAX_SLOT   = 8,
    parameter int              SPR_W      = 16,
    parameter int              SPR_H      = 16,
    parameter int              PIX_W      = 16,
    parameter logic [PIX_W-1:0] TRANSP_KEY = '0,
    parameter int              ROM_AW     = 8 + $clog2(SPR_W * SPR_H)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          line_start,
    input  logic [9:0]                    vcount,
    input  logic                          commit,
    input  logic                          spr_wr_en,
    input  logic [$clog2(NUM_SPRITE)-1:0] spr_wr_idx,
    input  logic [31:0]                   spr_wr_data,
    output logic [ROM_AW-1:0]             rom_addr,
    input  logic [PIX_W-1:0]              rom_q,
    output logic [9:0]                    pixel_col,
    output logic [PIX_W-1:0]              pixel_data,
    output logic                          pixel_wren,
    output logic                          overflow,
    output logic                          busy,
    output logic                          done
);

    localparam int IW = $clog2(NUM_SPRITE);
    localparam int CW = $clog2(NUM_SPRITE + 1);
    localparam int SW = $clog2(MAX_SLOT + 1);
    localparam int PW = $clog2(MAX_SLOT);
    localparam int XW = $clog2(SPR_W + 1);
    localparam int XB = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);

    typedef enum logic [1:0] {IDLE, SCAN, DRAW, DONE} state_t;

    typedef struct packed {
        logic [9:0]    col;
        logic [7:0]    frame;
        logic          hflip;
        logic [RW-1:0] row_off;
    } slot_t;

    state_t         state_q, state_d;
    logic           bank_sel_q, bank_sel_d;
    logic           commit_pend_q, commit_pend_d;
    logic [9:0]     tgt_q, tgt_d, tgt_next;
    logic [CW-1:0]  scan_cnt_q, scan_cnt_d;
    logic           rd_valid_q, rd_valid_d;
    slot_t          slot_q [MAX_SLOT];
    slot_t          slot_d [MAX_SLOT];
    logic [SW-1:0]  slot_cnt_q, slot_cnt_d;
    logic           overflow_q, overflow_d;
    logic [PW-1:0]  draw_slot_q, draw_slot_d;
    logic [XW-1:0]  draw_x_q, draw_x_d;
    logic           stg_valid_q, stg_valid_d;
    logic [10:0]    stg_col_q, stg_col_d;
    logic           enter_done, swap;

    logic [31:0]    bank_mem [2][NUM_SPRITE];
    logic [31:0]    attr_rd_q;

    logic [10:0]    tgt_ext, row_ext, row_diff;
    logic           hit;
    slot_t          hit_slot, cur_slot;
    logic [XB-1:0]  x_lo, x_pat;
    logic           unused_attr;

    assign tgt_next = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;

    // Writes always target the back bank; the scan reads the active bank with one cycle of latency.
    always_ff @(posedge clk) begin
        if (spr_wr_en) begin
            bank_mem[~bank_sel_q][spr_wr_idx] <= spr_wr_data;
        end
        attr_rd_q <= bank_mem[bank_sel_q][scan_cnt_q[IW-1:0]];
    end

    assign tgt_ext  = {1'b0, tgt_q};
    assign row_ext  = {2'b00, attr_rd_q[26:18]};
    assign row_diff = tgt_ext - row_ext;
    assign hit      = attr_rd_q[31] && (tgt_ext >= row_ext) && (tgt_ext < row_ext + 11'(SPR_H));
    assign unused_attr = ^attr_rd_q[28:27];

    always_comb begin
        hit_slot.col     = attr_rd_q[17:8];
        hit_slot.frame   = attr_rd_q[7:0];
        hit_slot.hflip   = attr_rd_q[30];
        hit_slot.row_off = attr_rd_q[29] ? ~row_diff[RW-1:0] : row_diff[RW-1:0];
    end

    assign cur_slot = slot_q[draw_slot_q];
    assign x_lo     = draw_x_q[XB-1:0];
    assign x_pat    = cur_slot.hflip ? ~x_lo : x_lo;

    assign busy       = (state_q == SCAN) || (state_q == DRAW);
    assign done       = (state_q == DONE);
    assign overflow   = overflow_q;
    assign rom_addr   = ((state_q == DRAW) && (draw_x_q < XW'(SPR_W)))
                        ? ROM_AW'({cur_slot.frame, cur_slot.row_off, x_pat}) : '0;
    assign pixel_col  = stg_valid_q ? stg_col_q[9:0] : '0;
    assign pixel_data = stg_valid_q ? rom_q : '0;
    assign pixel_wren = stg_valid_q && (rom_q != TRANSP_KEY) && (stg_col_q <= 11'd639);

    // Next-state logic; line_start overrides whatever the current state decided.
    always_comb begin
        state_d       = state_q;
        bank_sel_d    = bank_sel_q;
        commit_pend_d = commit_pend_q;
        tgt_d         = tgt_q;
        scan_cnt_d    = scan_cnt_q;
        rd_valid_d    = 1'b0;
        slot_d        = slot_q;
        slot_cnt_d    = slot_cnt_q;
        overflow_d    = overflow_q;
        draw_slot_d   = draw_slot_q;
        draw_x_d      = draw_x_q;
        stg_valid_d   = 1'b0;
        stg_col_d     = stg_col_q;
        enter_done    = 1'b0;
        swap          = 1'b0;

        if (commit) begin
            if (busy) commit_pend_d = 1'b1;
            else      swap = 1'b1;
        end

        case (state_q)
            SCAN: begin
                if (scan_cnt_q < CW'(NUM_SPRITE)) begin
                    rd_valid_d = 1'b1;
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
                if (rd_valid_q && hit) begin
                    if (slot_cnt_q < SW'(MAX_SLOT)) begin
                        slot_d[slot_cnt_q[PW-1:0]] = hit_slot;
                        slot_cnt_d = slot_cnt_q + 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if ((scan_cnt_q == CW'(NUM_SPRITE)) && !rd_valid_q) begin
                    if (slot_cnt_q == '0) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d     = DRAW;
                        draw_slot_d = PW'(slot_cnt_q - 1'b1);
                        draw_x_d    = '0;
                    end
                end
            end
            DRAW: begin
                if (draw_x_q < XW'(SPR_W)) begin
                    stg_valid_d = 1'b1;
                    stg_col_d   = 11'(cur_slot.col) + 11'(draw_x_q);
                    draw_x_d    = draw_x_q + 1'b1;
                end else if (draw_slot_q == '0) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end else begin
                    draw_slot_d = draw_slot_q - 1'b1;
                    draw_x_d    = '0;
                end
            end
            default: ;
        endcase

        if (line_start) begin
            overflow_d  = 1'b0;
            slot_cnt_d  = '0;
            scan_cnt_d  = '0;
            rd_valid_d  = 1'b0;
            stg_valid_d = 1'b0;
            tgt_d       = tgt_next;
            enter_done  = (tgt_next >= 10'd480);
            state_d     = enter_done ? DONE : SCAN;
        end

        // A commit that arrived while busy is applied as the line finishes.
        if (enter_done && (commit_pend_q || commit)) begin
            swap          = 1'b1;
            commit_pend_d = 1'b0;
        end
        if (swap) bank_sel_d = ~bank_sel_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            bank_sel_q    <= 1'b0;
            commit_pend_q <= 1'b0;
            tgt_q         <= '0;
            scan_cnt_q    <= '0;
            rd_valid_q    <= 1'b0;
            for (int i = 0; i < MAX_SLOT; i++) slot_q[i] <= '0;
            slot_cnt_q    <= '0;
            overflow_q    <= 1'b0;
            draw_slot_q   <= '0;
            draw_x_q      <= '0;
            stg_valid_q   <= 1'b0;
            stg_col_q     <= '0;
        end else begin
            state_q       <= state_d;
            bank_sel_q    <= bank_sel_d;
            commit_pend_q <= commit_pend_d;
            tgt_q         <= tgt_d;
            scan_cnt_q    <= scan_cnt_d;
            rd_valid_q    <= rd_valid_d;
            slot_q        <= slot_d;
            slot_cnt_q    <= slot_cnt_d;
            overflow_q    <= overflow_d;
            draw_slot_q   <= draw_slot_d;
            draw_x_q      <= draw_x_d;
            stg_valid_q   <= stg_valid_d;
            stg_col_q     <= stg_col_d;
        end
    end

endmodule

// File: tb/tb_sprite_line_engine.sv
// Scoreboard bench for sprite_line_engine: stimulus queues expected line-buffer
// writes, a negedge monitor pops and compares every pixel_wren.
module tb_sprite_line_engine;

    localparam int NS = 32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        line_start;
    logic [9:0]  vcount;
    logic        commit;
    logic        spr_wr_en;
    logic [4:0]  spr_wr_idx;
    logic [31:0] spr_wr_data;
    logic [15:0] rom_addr;
    logic [15:0] rom_q;
    logic [9:0]  pixel_col;
    logic [15:0] pixel_data;
    logic        pixel_wren;
    logic        overflow;
    logic        busy;
    logic        done;

    logic [15:0] rom_mem [65536];
    logic [15:0] line_buf [1024];
    logic [31:0] attr_tbl [NS];
    logic [25:0] sb_q [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc;

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom_mem[rom_addr];

    sprite_line_engine dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .line_start (line_start),
        .vcount     (vcount),
        .commit     (commit),
        .spr_wr_en  (spr_wr_en),
        .spr_wr_idx (spr_wr_idx),
        .spr_wr_data(spr_wr_data),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .pixel_col  (pixel_col),
        .pixel_data (pixel_data),
        .pixel_wren (pixel_wren),
        .overflow   (overflow),
        .busy       (busy),
        .done       (done)
    );

    // Monitor: every line-buffer write must match the oldest queued expectation.
    initial begin
        logic [25:0] exp_w;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && pixel_wren === 1'b1) begin
                checks++;
                line_buf[pixel_col] = pixel_data;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_wren: got col=%0d data=0x%0h, required no write", pixel_col, pixel_data);
                end else begin
                    exp_w = sb_q.pop_front();
                    if ({pixel_col, pixel_data} !== exp_w) begin
                        errors++;
                        $display("[TB] FAIL pixel: got col=%0d data=0x%0h, required col=%0d data=0x%0h",
                                 pixel_col, pixel_data, exp_w[25:16], exp_w[15:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic clearTbl();
        for (int i = 0; i < NS; i++) attr_tbl[i] = 32'h0;
    endtask

    // Writes the whole table into the back bank; commit rides on the final write when asked.
    task automatic writeBack(input bit commit_last);
        for (int i = NS - 1; i >= 0; i--) begin
            spr_wr_en   = 1'b1;
            spr_wr_idx  = 5'(i);
            spr_wr_data = attr_tbl[i];
            commit      = commit_last && (i == 0);
            tick();
        end
        spr_wr_en = 1'b0;
        commit    = 1'b0;
        tick();
    endtask

    task automatic commitNow();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
    endtask

    task automatic pushSprite(input int col, input int frame, input int roff, input bit hflip);
        int c;
        int a;
        for (int x = 0; x < 16; x++) begin
            c = col + x;
            a = frame * 256 + roff * 16 + (hflip ? 15 - x : x);
            if (c <= 639 && rom_mem[a] != 16'h0) sb_q.push_back({c[9:0], rom_mem[a]});
        end
    endtask

    task automatic waitDone(input string name, input int budget, input int commit_at, output int cycles);
        cycles = 1;
        while (done !== 1'b1 && cycles < budget) begin
            if (cycles == commit_at) begin
                checkOutput({name, "_busy_at_commit"}, 32'(busy), 32'd1);
                commit = 1'b1;
            end
            tick();
            commit = 1'b0;
            cycles++;
        end
        checkOutput({name, "_done"}, 32'(done), 32'd1);
        checkOutput({name, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic applyStimulus(input string name, input logic [9:0] vc, input int budget,
                                 input int commit_at, output int cycles);
        vcount     = vc;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        waitDone(name, budget, commit_at, cycles);
    endtask

    task automatic waitDrained(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        checkOutput({name, "_partial_seen"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom_mem[i] = 16'(i + 1);
        reset_n     = 1'b0;
        line_start  = 1'b0;
        vcount      = 10'd0;
        commit      = 1'b0;
        spr_wr_en   = 1'b0;
        spr_wr_idx  = 5'd0;
        spr_wr_data = 32'h0;
        repeat (3) tick();
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_wren", 32'(pixel_wren), 32'd0);
        checkOutput("reset_rom_addr", 32'(rom_addr), 32'd0);
        reset_n = 1'b1;
        tick();

        // Basic draw: row 192, col 256, frame 1 on line 192
        clearTbl();
        attr_tbl[0] = 32'h83010001;
        writeBack(1'b0);
        commitNow();
        pushSprite(256, 1, 0, 0);
        applyStimulus("t1", 10'd191, 200, -1, cyc);
        checkOutput("t1_within_164", 32'(cyc <= 164), 32'd1);
        checkOutput("t1_overflow", 32'(overflow), 32'd0);
        checkOutput("t1_busy_done", 32'(busy), 32'd0);
        checkOutput("t1_col256", 32'(line_buf[256]), 32'd257);
        checkOutput("t1_col271", 32'(line_buf[271]), 32'd272);

        // Horizontal flip: col 256 carries rom word 271
        attr_tbl[0] = 32'hC3010001;
        writeBack(1'b0);
        commitNow();
        pushSprite(256, 1, 0, 1);
        applyStimulus("t2h", 10'd191, 200, -1, cyc);
        checkOutput("t2h_col256", 32'(line_buf[256]), 32'd272);

        // Vertical flip: row_off 15, addresses 496..511
        attr_tbl[0] = 32'hA3010001;
        writeBack(1'b0);
        commitNow();
        pushSprite(256, 1, 15, 0);
        applyStimulus("t2v", 10'd191, 200, -1, cyc);
        checkOutput("t2v_col256", 32'(line_buf[256]), 32'd497);
        checkOutput("t2v_col271", 32'(line_buf[271]), 32'd512);

        // Right-edge clipping at col 630 plus a transparent word at addr 258
        rom_mem[258] = 16'h0;
        line_buf[632] = 16'hFFFF;
        attr_tbl[0] = 32'h83027601;
        writeBack(1'b0);
        commitNow();
        pushSprite(630, 1, 0, 0);
        applyStimulus("t3", 10'd191, 200, -1, cyc);
        checkOutput("t3_col639", 32'(line_buf[639]), 32'd266);
        checkOutput("t3_col632_untouched", 32'(line_buf[632]), 32'hFFFF);
        rom_mem[258] = 16'd259;

        // Nine sprites on one line: eight drawn highest index first, idx 8 dropped
        clearTbl();
        for (int i = 0; i < 9; i++) attr_tbl[i] = 32'h81900000 | (i << 8);
        writeBack(1'b0);
        commitNow();
        for (int s = 7; s >= 0; s--) pushSprite(s, 0, 0, 0);
        applyStimulus("t4", 10'd99, 200, -1, cyc);
        checkOutput("t4_overflow", 32'(overflow), 32'd1);
        checkOutput("t4_within_172", 32'(cyc <= 172), 32'd1);
        checkOutput("t4_col7_idx0_wins", 32'(line_buf[7]), 32'd8);
        checkOutput("t4_col22_idx7", 32'(line_buf[22]), 32'd16);

        // Commit during DRAW: current line keeps frame 1, next line sees frame 2
        clearTbl();
        attr_tbl[0] = 32'h83010001;
        writeBack(1'b0);
        commitNow();
        attr_tbl[0] = 32'h83010002;
        writeBack(1'b0);
        pushSprite(256, 1, 0, 0);
        applyStimulus("t5a", 10'd191, 200, 40, cyc);
        checkOutput("t5a_old_bank", 32'(line_buf[256]), 32'd257);
        pushSprite(256, 2, 0, 0);
        applyStimulus("t5b", 10'd191, 200, -1, cyc);
        checkOutput("t5b_new_bank", 32'(line_buf[256]), 32'd513);

        // Write and commit in the same idle cycle
        attr_tbl[0] = 32'h83010003;
        writeBack(1'b1);
        pushSprite(256, 3, 0, 0);
        applyStimulus("t5c", 10'd191, 200, -1, cyc);
        checkOutput("t5c_same_cycle", 32'(line_buf[256]), 32'd769);

        // Abort after five pixels; the restarted line draws the full sprite
        for (int x = 0; x < 5; x++) sb_q.push_back({10'(256 + x), 16'(769 + x)});
        vcount     = 10'd191;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        waitDrained("t6a");
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        checkOutput("t6a_wren_dropped", 32'(pixel_wren), 32'd0);
        checkOutput("t6a_rescan_busy", 32'(busy), 32'd1);
        pushSprite(256, 3, 0, 0);
        waitDone("t6a", 200, -1, cyc);

        // Asynchronous reset during DRAW
        for (int x = 0; x < 3; x++) sb_q.push_back({10'(256 + x), 16'(769 + x)});
        vcount     = 10'd191;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        waitDrained("t6b");
        reset_n = 1'b0;
        #1;
        checkOutput("t6b_wren", 32'(pixel_wren), 32'd0);
        checkOutput("t6b_col", 32'(pixel_col), 32'd0);
        checkOutput("t6b_data", 32'(pixel_data), 32'd0);
        checkOutput("t6b_rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("t6b_busy", 32'(busy), 32'd0);
        checkOutput("t6b_overflow", 32'(overflow), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        checkOutput("t6b_idle_done", 32'(done), 32'd0);
        checkOutput("t6b_idle_busy", 32'(busy), 32'd0);

        // Blank lines finish one cycle after line_start
        applyStimulus("t7a", 10'd500, 20, -1, cyc);
        checkOutput("t7a_one_cycle", 32'(cyc), 32'd1);
        checkOutput("t7a_busy", 32'(busy), 32'd0);
        applyStimulus("t7b", 10'd479, 20, -1, cyc);
        checkOutput("t7b_one_cycle", 32'(cyc), 32'd1);

        // vcount 524 wraps to target line 0
        clearTbl();
        attr_tbl[0] = 32'h80006401;
        writeBack(1'b0);
        commitNow();
        pushSprite(100, 1, 0, 0);
        applyStimulus("t8", 10'd524, 200, -1, cyc);
        checkOutput("t8_col100", 32'(line_buf[100]), 32'd257);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
